// File: rtl/uart_xmit.sv
// uart_xmit: UART serialiser. Start, 8 data LSB first, optional parity, 1-2 stop.
// Ports: clk, rst, start_xmit, xmit_data[7:0] in; sout, xmitting, done_xmitting out.
module uart_xmit #(
  parameter int BAUD_DIV   = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_xmit,
  input  logic [7:0] xmit_data,
  output logic       sout,
  output logic       xmitting,
  output logic       done_xmitting
);

  localparam int TW = $clog2(BAUD_DIV);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    shift;
  logic          par;
  logic          bit_end;
  logic          last_stop;

  assign bit_end   = (timer == TW'(BAUD_DIV - 1));
  assign last_stop = (STOP_BITS == 1) || stop_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      timer         <= '0;
      bit_idx       <= '0;
      stop_idx      <= 1'b0;
      shift         <= '0;
      par           <= 1'b0;
      sout          <= 1'b1;
      xmitting      <= 1'b0;
      done_xmitting <= 1'b0;
    end else begin
      done_xmitting <= 1'b0;
      if (state != S_IDLE)
        timer <= bit_end ? '0 : timer + 1'b1;
      case (state)
        S_IDLE: begin
          if (start_xmit) begin
            state    <= S_START;
            timer    <= '0;
            shift    <= xmit_data;
            // parity fixed at capture, so later data changes cannot leak in
            par      <= (^xmit_data) ^ (PARITY_ODD != 0);
            sout     <= 1'b0;
            xmitting <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
            sout    <= shift[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
              stop_idx <= 1'b0;
              if (PARITY_EN != 0) begin
                state <= S_PARITY;
                sout  <= par;
              end else begin
                state <= S_STOP;
                sout  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              sout    <= shift[1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state    <= S_STOP;
            stop_idx <= 1'b0;
            sout     <= 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              state         <= S_IDLE;
              xmitting      <= 1'b0;
              done_xmitting <= 1'b1;
              sout          <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          sout     <= 1'b1;
          xmitting <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xmit.sv
// tb_uart_xmit: directed bench for uart_xmit in four parameterisations.
// Ports: none; drives shared inputs, checks one instance per frame.
module tb_uart_xmit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic [3:0] so, xm, dn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_xmit #(.BAUD_DIV(4)) u_a (
    .clk(clk), .rst(rst), .start_xmit(start), .xmit_data(data),
    .sout(so[0]), .xmitting(xm[0]), .done_xmitting(dn[0]));

  uart_xmit #(.BAUD_DIV(4), .PARITY_EN(1)) u_b (
    .clk(clk), .rst(rst), .start_xmit(start), .xmit_data(data),
    .sout(so[1]), .xmitting(xm[1]), .done_xmitting(dn[1]));

  uart_xmit #(.BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1)) u_c (
    .clk(clk), .rst(rst), .start_xmit(start), .xmit_data(data),
    .sout(so[2]), .xmitting(xm[2]), .done_xmitting(dn[2]));

  uart_xmit #(.BAUD_DIV(4), .STOP_BITS(2)) u_d (
    .clk(clk), .rst(rst), .start_xmit(start), .xmit_data(data),
    .sout(so[3]), .xmitting(xm[3]), .done_xmitting(dn[3]));

  task automatic check(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // exp bit k is the k-th serial bit; each bit lasts 4 cycles
  task automatic run_frame(input int s, input logic [7:0] d, input int nb,
                           input logic [11:0] exp, input bit start_now,
                           input int inj, input bit chain,
                           input logic [7:0] nd);
    if (start_now) begin
      @(posedge clk);
      #1 start = 1'b1;
      data = d;
    end
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check("frame", {9'd0, xm[s], so[s], dn[s]}, {9'd0, 1'b1, exp[k], 1'b0});
        if (k * 4 + c == inj) begin
          start = 1'b1;
          data  = 8'h3C;
        end else if (k * 4 + c == inj + 1) begin
          start = 1'b0;
        end
      end
    end
    @(negedge clk);
    check("done", {9'd0, xm[s], so[s], dn[s]}, 12'b011);
    if (chain) begin
      start = 1'b1;
      data  = nd;
    end else begin
      @(negedge clk);
      check("done_clr", {9'd0, xm[s], so[s], dn[s]}, 12'b010);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    data  = 8'h00;
    #2;
    check("rst_init", {so, xm, dn}, 12'hF00);
    repeat (3) @(negedge clk);
    check("rst_hold", {so, xm, dn}, 12'hF00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(0, 8'hA5, 10, 12'h34A, 1'b1, 10, 1'b0, 8'h00);
    repeat (8) begin
      @(negedge clk);
      check("no_second", {10'd0, xm[0], dn[0]}, 12'h000);
    end

    run_frame(0, 8'hA5, 10, 12'h34A, 1'b1, -1, 1'b1, 8'h00);
    run_frame(0, 8'h00, 10, 12'h200, 1'b0, -1, 1'b0, 8'h00);

    do_reset();
    run_frame(1, 8'h07, 11, 12'h60E, 1'b1, -1, 1'b0, 8'h00);
    do_reset();
    run_frame(2, 8'h07, 11, 12'h40E, 1'b1, -1, 1'b0, 8'h00);

    do_reset();
    run_frame(3, 8'hFF, 11, 12'h7FE, 1'b1, -1, 1'b0, 8'h00);

    @(posedge clk);
    #1 start = 1'b1;
    data = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async", {so, xm, dn}, 12'hF00);
    repeat (5) begin
      @(negedge clk);
      check("rst_hold5", {so, xm, dn}, 12'hF00);
    end
    rst = 1'b0;
    repeat (50) begin
      @(negedge clk);
      check("no_done", {so, xm, dn}, 12'hF00);
    end
    run_frame(3, 8'hFF, 11, 12'h7FE, 1'b1, -1, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
